// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        BLANK = 1'b0,
        DWELL = 1'b1
    } scan_state_t;

    // Larger of two integers, used to size the shared interval counter.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// Loadable down counter that saturates at zero and flags it; one instance
// times both the blanking and the dwell intervals.
module scan_timer #(
    parameter int               CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count down toward zero, reloading whenever the owner asks.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= RESET_VAL;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered digit word,
// one active-low enable per digit, blanking before every dwell, and buffer
// swaps only at frame boundaries so a frame never mixes old and new digits.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_digits,
    output logic [DIGIT_W-1:0]            digit_val,
    output logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic                          frame_start
);

    localparam int WORD_W  = DIGIT_W * NUM_DIGITS;
    localparam int MAX_CYC = max_int(DWELL_CYCLES, BLANK_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t       state_r;
    scan_state_t       state_next_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_next_s;
    logic              timer_zero_s;
    logic              timer_load_s;
    logic [CNT_W-1:0]  timer_load_val_s;
    logic              frame_start_s;
    logic              copy_s;
    logic              accept_s;
    logic [WORD_W-1:0] shadow_r;
    logic [WORD_W-1:0] active_r;
    logic              pending_r;
    logic [NUM_DIGITS-1:0] digit_en_n_s;

    scan_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (BLANK_LOAD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_s),
        .load_val (timer_load_val_s),
        .zero     (timer_zero_s)
    );

    // Next-state logic: alternate blank/dwell, advance the digit after each dwell.
    always_comb begin
        state_next_s     = state_r;
        idx_next_s       = idx_r;
        timer_load_s     = 1'b0;
        timer_load_val_s = BLANK_LOAD;
        frame_start_s    = 1'b0;
        case (state_r)
            BLANK: begin
                if (timer_zero_s) begin
                    state_next_s     = DWELL;
                    timer_load_s     = 1'b1;
                    timer_load_val_s = DWELL_LOAD;
                    frame_start_s    = (idx_r == {IDX_W{1'b0}});
                end else begin
                    state_next_s = BLANK;
                end
            end
            DWELL: begin
                if (timer_zero_s) begin
                    state_next_s     = BLANK;
                    timer_load_s     = 1'b1;
                    timer_load_val_s = BLANK_LOAD;
                    if (idx_r == LAST_IDX) begin
                        idx_next_s = {IDX_W{1'b0}};
                    end else begin
                        idx_next_s = idx_r + IDX_W'(1'b1);
                    end
                end else begin
                    state_next_s = DWELL;
                end
            end
            default: begin
                state_next_s     = BLANK;
                idx_next_s       = {IDX_W{1'b0}};
                timer_load_s     = 1'b1;
                timer_load_val_s = BLANK_LOAD;
            end
        endcase
    end

    // A swap needs both a frame boundary and a waiting word; acceptance needs room.
    always_comb begin
        copy_s   = frame_start_s & pending_r;
        accept_s = load_valid & ~pending_r;
    end

    // Scan state and digit index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= BLANK;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Double buffer: shadow takes new words, active is swapped only at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r  <= {WORD_W{1'b0}};
            active_r  <= {WORD_W{1'b0}};
            pending_r <= 1'b0;
        end else if (copy_s) begin
            active_r  <= shadow_r;
            pending_r <= 1'b0;
        end else if (accept_s) begin
            shadow_r  <= load_digits;
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Enable decode: all dark while blanking, exactly the current digit while dwelling.
    always_comb begin
        digit_en_n_s = {NUM_DIGITS{1'b1}};
        if (state_r == DWELL) begin
            digit_en_n_s[idx_r] = 1'b0;
        end else begin
            digit_en_n_s = {NUM_DIGITS{1'b1}};
        end
    end

    assign digit_en_n  = digit_en_n_s;
    assign digit_val   = active_r[int'(idx_r)*DIGIT_W +: DIGIT_W];
    assign load_ready  = ~pending_r;
    assign frame_start = frame_start_s;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-level reference model computes
// each cycle's expected outputs from frame arithmetic and a buffer model; a
// separate monitor pops and compares them against the DUT on the falling edge.
module tb_seg_scan_ctrl;

    localparam int ND    = 2;
    localparam int DW    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = ND * SLOT;

    typedef struct {
        int         cyc;
        logic [1:0] en;
        logic [3:0] val;
        logic       rdy;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_digits;
    logic [3:0] digit_val;
    logic [1:0] digit_en_n;
    logic       frame_start;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // reference model state
    int       t;
    logic [7:0] m_active;
    logic [7:0] m_shadow;
    logic     m_pending;
    logic     m_acc;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .digit_val   (digit_val),
        .digit_en_n  (digit_en_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, push the expected outputs, advance the model.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        exp_t e;
        int   pos;
        int   slot;
        int   w;
        reset       = r;
        load_valid  = v;
        load_digits = d;
        pos   = t % FRAME;
        slot  = pos / SLOT;
        w     = pos % SLOT;
        e.cyc = t;
        e.en  = 2'b11;
        if (w >= BL) e.en[slot] = 1'b0;
        e.val = m_active[4*slot +: 4];
        e.rdy = !m_pending;
        e.fs  = (slot == 0) && (w == BL - 1);
        exp_q.push_back(e);
        m_acc = 1'b0;
        if (r) begin
            t         = 0;
            m_active  = 8'h00;
            m_shadow  = 8'h00;
            m_pending = 1'b0;
        end else begin
            m_acc = v && !m_pending;
            if (e.fs && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end else if (m_acc) begin
                m_shadow  = d;
                m_pending = 1'b1;
            end
            t = t + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (digit_en_n !== e.en) begin
                n_bad++;
                $display("FAIL en cyc=%0d got=%b exp=%b", e.cyc, digit_en_n, e.en);
            end
            if (digit_val !== e.val) begin
                n_bad++;
                $display("FAIL val cyc=%0d got=%h exp=%h", e.cyc, digit_val, e.val);
            end
            if (load_ready !== e.rdy) begin
                n_bad++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", e.cyc, load_ready, e.rdy);
            end
            if (frame_start !== e.fs) begin
                n_bad++;
                $display("FAIL fstart cyc=%0d got=%b exp=%b", e.cyc, frame_start, e.fs);
            end
            if ($countones(~digit_en_n) > 1) begin
                n_bad++;
                $display("FAIL onehot cyc=%0d got=%b exp=at most one low", e.cyc, digit_en_n);
            end
        end
    end

    initial begin
        int stage;
        int drain;
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_digits = 8'h00;
        t           = 0;
        m_active    = 8'h00;
        m_shadow    = 8'h00;
        m_pending   = 1'b0;
        m_acc       = 1'b0;
        @(posedge clk);
        #1;

        // reset release, no load
        step(1'b1, 1'b0, 8'h00);
        idle(24);

        // first word at cycle 0, second word mid-frame at cycle 5
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3A);
        idle(4);
        step(1'b0, 1'b1, 8'h5C);
        idle(40);

        // valid held across two back-to-back words
        step(1'b1, 1'b0, 8'h00);
        stage = 0;
        for (int i = 0; i < 70; i++) begin
            step(1'b0, stage < 2, (stage == 0) ? 8'h77 : 8'h99);
            if (m_acc) stage++;
        end

        // reset while digit 1 is lit and a word is pending
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3A);
        idle(2);
        step(1'b0, 1'b1, 8'h5C);
        idle(10);
        step(1'b1, 1'b0, 8'h00);
        idle(25);

        // randomized traffic with occasional reset
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom));
        end
        load_valid = 1'b0;

        drain = 0;
        while (exp_q.size() > 0 && drain < 4) begin
            @(negedge clk);
            drain++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
